// File: rtl/axis_position_emulator.sv
`timescale 1ns/1ps
// axis_position_emulator
// Quadrature (A/B) sample source. Signed target positions arrive on an
// AXI4-Stream slave; an internal position counter walks toward each target
// one phase step at a time, and the {B, A} sample stream leaves on an
// AXI4-Stream master.
// Optional build macro: POSITION_EMU_RETARGET_EN. It accepts new targets
// while a move is in progress. When it is undefined, targets are taken
// only in IDLE.
module axis_position_emulator #(
   parameter int unsigned S_AXIS_TDATA_WIDTH = 16,
   parameter int unsigned M_AXIS_TDATA_WIDTH = 32
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [M_AXIS_TDATA_WIDTH/2-1:0] low_level,
   input  logic [M_AXIS_TDATA_WIDTH/2-1:0] high_level,
   input  logic [15:0]                     step_div,
   input  logic                            S_AXIS_tvalid,
   input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
   output logic                            S_AXIS_tready,
   input  logic                            M_AXIS_tready,
   output logic                            M_AXIS_tvalid,
   output logic [M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata,
   output logic                            busy
);

   localparam int unsigned HALF_W = M_AXIS_TDATA_WIDTH / 2;
   localparam int unsigned POS_W  = S_AXIS_TDATA_WIDTH;
   localparam int unsigned DIV_W  = 16;

   typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;

   state_t            state;
   logic [POS_W-1:0]  position;
   logic [POS_W-1:0]  target;
   logic [1:0]        phase;
   logic [DIV_W-1:0]  divider;

   logic [DIV_W-1:0]  div_last_c;
   logic              s_hs_c;
   logic              step_c;
   logic              fwd_c;
   logic              done_c;
   logic [POS_W-1:0]  step_pos_c;
   logic [1:0]        step_phase_c;
   logic [HALF_W-1:0] a_lvl_c;
   logic [HALF_W-1:0] b_lvl_c;

   // Step-rate compare, step direction and move-completion decode
   always_comb begin
      done_c       = 1'b0;
      div_last_c   = (step_div == '0) ? '0 : step_div - DIV_W'(1);
      s_hs_c       = S_AXIS_tvalid && S_AXIS_tready;
      step_c       = (state == MOVE) && M_AXIS_tready && (divider == div_last_c);
      fwd_c        = $signed(target) > $signed(position);
      step_pos_c   = fwd_c ? position + POS_W'(1) : position - POS_W'(1);
      step_phase_c = fwd_c ? phase + 2'd1 : phase - 2'd1;
`ifdef POSITION_EMU_RETARGET_EN
      // A step in the same cycle as a retarget moves toward the old target
      // but completes against the new one.
      if (step_c) begin
         done_c = (step_pos_c == (s_hs_c ? S_AXIS_tdata : target));
      end else begin
         done_c = (state == MOVE) && s_hs_c && (S_AXIS_tdata == position);
      end
`else
      done_c = step_c && (step_pos_c == target);
`endif
   end

   // Phase to channel level map: A high in phases 1 and 2, B high in 2 and 3
   always_comb begin
      a_lvl_c = (phase[0] ^ phase[1]) ? high_level : low_level;
      b_lvl_c = phase[1] ? high_level : low_level;
   end

   // Move FSM, position/phase counters and registered stream outputs
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= IDLE;
         position      <= '0;
         target        <= '0;
         phase         <= '0;
         divider       <= '0;
         S_AXIS_tready <= 1'b0;
         M_AXIS_tvalid <= 1'b0;
         M_AXIS_tdata  <= '0;
         busy          <= 1'b0;
      end else begin
         M_AXIS_tvalid <= 1'b1;
         // Sample register only advances when the consumer takes the word
         if (!M_AXIS_tvalid || M_AXIS_tready) begin
            M_AXIS_tdata <= {b_lvl_c, a_lvl_c};
         end
         case (state)
            IDLE: begin
               S_AXIS_tready <= 1'b1;
               divider       <= '0;
               if (s_hs_c) begin
                  target <= S_AXIS_tdata;
                  if (S_AXIS_tdata != position) begin
                     state <= MOVE;
                     busy  <= 1'b1;
`ifndef POSITION_EMU_RETARGET_EN
                     S_AXIS_tready <= 1'b0;
`endif
                  end
               end
            end
            MOVE: begin
               // Divider freezes under output backpressure
               if (M_AXIS_tready) begin
                  divider <= step_c ? '0 : divider + DIV_W'(1);
               end
               if (step_c) begin
                  position <= step_pos_c;
                  phase    <= step_phase_c;
               end
`ifdef POSITION_EMU_RETARGET_EN
               if (s_hs_c) begin
                  target <= S_AXIS_tdata;
               end
`endif
               if (done_c) begin
                  state         <= IDLE;
                  busy          <= 1'b0;
                  S_AXIS_tready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_position_emulator.sv
`timescale 1ns/1ps
// Scoreboarded bench for axis_position_emulator (default build).
module tb_axis_position_emulator;

   localparam logic [15:0] LO = 16'hFC18;   // -1000
   localparam logic [15:0] HI = 16'h03E8;   // +1000

   logic        aclk = 1'b0;
   logic        areset = 1'b0;
   logic [15:0] low_level;
   logic [15:0] high_level;
   logic [15:0] step_div;
   logic        S_AXIS_tvalid;
   logic [15:0] S_AXIS_tdata;
   logic        S_AXIS_tready;
   logic        M_AXIS_tready;
   logic        M_AXIS_tvalid;
   logic [31:0] M_AXIS_tdata;
   logic        busy;

   int          n_checks = 0;
   int          n_fail = 0;
   int          fwd_falls = 0;
   int          rev_falls = 0;
   logic [31:0] sb[$];
   logic [31:0] last_smp;

   axis_position_emulator dut (
      .aclk          (aclk),
      .areset        (areset),
      .low_level     (low_level),
      .high_level    (high_level),
      .step_div      (step_div),
      .S_AXIS_tvalid (S_AXIS_tvalid),
      .S_AXIS_tdata  (S_AXIS_tdata),
      .S_AXIS_tready (S_AXIS_tready),
      .M_AXIS_tready (M_AXIS_tready),
      .M_AXIS_tvalid (M_AXIS_tvalid),
      .M_AXIS_tdata  (M_AXIS_tdata),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] lv(input int ph);
      case (ph)
         0:       lv = {LO, LO};
         1:       lv = {LO, HI};
         2:       lv = {HI, HI};
         default: lv = {HI, LO};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected {B,A} levels for n steps from phase 'start' in direction dir
   task automatic push_seq(input int start, input int n, input int dir);
      int ph = start;
      for (int i = 0; i < n; i++) begin
         ph = (ph + dir + 4) % 4;
         sb.push_back(lv(ph));
      end
   endtask

   task automatic send(input logic [15:0] t, input int budget);
      int k = 0;
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = t;
      while (!S_AXIS_tready && k < budget) begin
         @(negedge aclk);
         k++;
      end
      check("send_accept", 32'(S_AXIS_tready), 32'd1);
      @(posedge aclk);
      #1 S_AXIS_tvalid = 1'b0;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy && cnt < 2000) begin
         @(posedge aclk);
         #1;
         cnt++;
      end
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge aclk);
      check(name, 32'(sb.size()), 32'd0);
   endtask

   // Monitor: every change in the consumed sample stream must match the queue
   always @(negedge aclk) begin
      if (areset) begin
         last_smp = {LO, LO};
      end else if (M_AXIS_tvalid === 1'b1 && M_AXIS_tready && M_AXIS_tdata != last_smp) begin
         if (last_smp[15:0] == HI && M_AXIS_tdata[15:0] == LO) begin
            if (M_AXIS_tdata[31:16] == HI) fwd_falls++;
            else rev_falls++;
         end
         if (sb.size() == 0) check("unexpected_sample", M_AXIS_tdata, last_smp);
         else check("sample_seq", M_AXIS_tdata, sb.pop_front());
         last_smp = M_AXIS_tdata;
      end
   end

   initial begin
      int          cnt;
      int          f0;
      int          r0;
      int          rdy_cnt;
      logic [31:0] held;

      low_level     = LO;
      high_level    = HI;
      step_div      = 16'd4;
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tdata  = '0;
      M_AXIS_tready = 1'b1;

      // Reset values, then first sample after release
      #1 areset = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      check("rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
      check("rst_tdata", M_AXIS_tdata, 32'd0);
      check("rst_s_tready", 32'(S_AXIS_tready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge aclk) areset = 1'b0;
      @(posedge aclk);
      #1;
      check("post_tvalid", 32'(M_AXIS_tvalid), 32'd1);
      check("post_tdata", M_AXIS_tdata, {LO, LO});
      check("post_s_tready", 32'(S_AXIS_tready), 32'd1);
      check("post_busy", 32'(busy), 32'd0);

      // Target equal to position: accepted, no move
      send(16'd0, 10);
      check("eq_busy", 32'(busy), 32'd0);
      @(posedge aclk);
      #1;
      check("eq_busy2", 32'(busy), 32'd0);
      check("eq_tdata", M_AXIS_tdata, {LO, LO});
      check("eq_s_tready", 32'(S_AXIS_tready), 32'd1);

      // Forward to +8, one step every 4 cycles
      step_div = 16'd4;
      f0 = fwd_falls;
      r0 = rev_falls;
      push_seq(0, 8, 1);
      send(16'd8, 10);
      count_busy(cnt);
      check("fwd_busy_cycles", 32'(cnt), 32'd32);
      drain("fwd_drain");
      check("fwd_a_falls_bhigh", 32'(fwd_falls - f0), 32'd2);
      check("fwd_a_falls_blow", 32'(rev_falls - r0), 32'd0);
      check("fwd_final", M_AXIS_tdata, lv(0));

      // Reverse to -4, one step per cycle
      step_div = 16'd1;
      f0 = fwd_falls;
      r0 = rev_falls;
      push_seq(0, 12, -1);
      send(16'hFFFC, 10);
      count_busy(cnt);
      check("rev_busy_cycles", 32'(cnt), 32'd12);
      drain("rev_drain");
      check("rev_a_falls_blow", 32'(rev_falls - r0), 32'd3);
      check("rev_a_falls_bhigh", 32'(fwd_falls - f0), 32'd0);
      check("rev_final", M_AXIS_tdata, lv(0));

      // Back to 0, then +4 at step_div=2 with toggling backpressure
      push_seq(0, 4, 1);
      send(16'd0, 10);
      count_busy(cnt);
      check("to0_busy_cycles", 32'(cnt), 32'd4);
      drain("to0_drain");
      step_div = 16'd2;
      push_seq(0, 4, 1);
      send(16'd4, 10);
      rdy_cnt = 0;
      for (int i = 0; i < 100 && busy; i++) begin
         M_AXIS_tready = (i % 2 == 0);
         held = M_AXIS_tdata;
         @(posedge aclk);
         if (M_AXIS_tready) rdy_cnt++;
         #1;
         if (!M_AXIS_tready) check("bp_hold", M_AXIS_tdata, held);
      end
      M_AXIS_tready = 1'b1;
      check("bp_ready_cycles", 32'(rdy_cnt), 32'd8);
      drain("bp_drain");

      // Target +100; a second word stalls until the move completes
      step_div = 16'd1;
      push_seq(0, 96, 1);
      push_seq(0, 97, -1);
      send(16'd100, 10);
      repeat (5) @(posedge aclk);
      #1;
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 16'd3;
      @(negedge aclk);
      check("stall_s_tready", 32'(S_AXIS_tready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      send(16'd3, 300);
      count_busy(cnt);
      check("stall_rev_cycles", 32'(cnt), 32'd97);
      drain("stall_drain");

      // Asynchronous reset in the middle of a move
      push_seq(3, 97, 1);
      send(16'd100, 10);
      repeat (50) @(posedge aclk);
      #2 areset = 1'b1;
      #1;
      check("mr_tvalid", 32'(M_AXIS_tvalid), 32'd0);
      check("mr_tdata", M_AXIS_tdata, 32'd0);
      check("mr_s_tready", 32'(S_AXIS_tready), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      sb.delete();
      @(negedge aclk);
      @(negedge aclk) areset = 1'b0;
      @(posedge aclk);
      #1;
      check("mr_post_tvalid", 32'(M_AXIS_tvalid), 32'd1);
      check("mr_post_tdata", M_AXIS_tdata, {LO, LO});
      push_seq(0, 2, 1);
      send(16'd2, 10);
      count_busy(cnt);
      check("mr_move_cycles", 32'(cnt), 32'd2);
      drain("mr_drain");
      check("mr_final", M_AXIS_tdata, lv(2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_position_emulator.md
Name: axis_position_emulator

Overview:
- Synthesises two-channel quadrature samples, A and B, that a downstream position tracker decodes back into a displacement.
- Accepts signed target positions on an AXI4-Stream slave and walks an internal position counter toward each target, one quadrature phase step at a time.
- Emits packed {B, A} samples on an AXI4-Stream master at the sample rate.
- Used as a bench and self-test source in place of the ADC path.

Parameters:
- S_AXIS_TDATA_WIDTH, 16, width of the signed target position word.
- M_AXIS_TDATA_WIDTH, 32, width of the output sample word; A is in the low half, B is in the high half.

Ports:
- aclk  in  1  system clock.
- areset  in  1  reset; asynchronous, active-high.
- low_level  in  M_AXIS_TDATA_WIDTH/2  signed sample value driven for logic-low.
- high_level  in  M_AXIS_TDATA_WIDTH/2  signed sample value driven for logic-high.
- step_div  in  16  clock cycles per phase step; a value of 0 is treated as 1.
- S_AXIS_tvalid  in  1  target word valid.
- S_AXIS_tdata  in  S_AXIS_TDATA_WIDTH  signed target position, in phase steps.
- S_AXIS_tready  out  1  target accepted when high together with tvalid.
- M_AXIS_tready  in  1  sample consumer ready.
- M_AXIS_tvalid  out  1  sample valid.
- M_AXIS_tdata  out  M_AXIS_TDATA_WIDTH  {B, A} sample.
- busy  out  1  high while in MOVE.

Behaviour:
- Reset: areset is asynchronous and active-high. All outputs are driven as follows while areset is high:
  - M_AXIS_tvalid=0, M_AXIS_tdata=0, S_AXIS_tready=0, busy=0.
  - Internal state: position=0, target=0, phase=0, divider=0, state=IDLE.
- Reset mid-move: the move is abandoned with no completion; all registers return to the values above.
- After reset deasserts:
  - M_AXIS_tvalid=1 from the first clock edge and stays 1.
  - M_AXIS_tdata is registered and reflects the current phase with 1-cycle latency.
- Phase-to-level map (A, B):
  - phase 0 = (low, low)
  - phase 1 = (high, low)
  - phase 2 = (high, high)
  - phase 3 = (low, high)
- Direction: a forward step increments phase mod 4, so A falls while B is high. A reverse step decrements phase mod 4, so A falls while B is low. One full phase cycle equals one tracker count.
- State IDLE:
  - S_AXIS_tready=1.
  - On handshake, the target register is loaded. If the new target != position, go to MOVE and clear the divider. Otherwise remain in IDLE.
- State MOVE:
  - busy=1; S_AXIS_tready=0 (see Optional Feature).
  - The divider increments on every cycle in which M_AXIS_tready=1.
  - When divider reaches max(step_div,1)-1, a step occurs and the divider is cleared:
    - If $signed(target) > $signed(position): position+1, phase+1.
    - Otherwise: position-1, phase-1.
  - When the post-step position == target, return to IDLE in the same transition.
- Backpressure: while M_AXIS_tready=0, M_AXIS_tdata holds its value, the divider freezes and no step occurs. Each output sample advances at most one phase.
- Arithmetic: position and target are S_AXIS_TDATA_WIDTH signed. Movement is always toward the target, so position never wraps; moving from -32768 to 32767 takes 65535 steps.
- Timing: step_div is sampled every cycle; a change takes effect from the next divider compare.

Optional Feature:
- Macro: POSITION_EMU_RETARGET_EN.
- Defined:
  - S_AXIS_tready=1 in MOVE as well as IDLE.
  - A handshake in MOVE replaces the target immediately; the divider is not cleared and direction is re-evaluated at the next step.
  - If the new target equals the current position, go to IDLE at once.
  - If a handshake coincides with a step, the step uses the old target and the completion check uses the new target.
- Undefined: S_AXIS_tready=0 in MOVE; targets are accepted only in IDLE.

Test Plan:
- Reset with low=-1000, high=1000 -> tdata=0, tvalid=0; one cycle after release, tvalid=1 and tdata={-1000,-1000}; S_AXIS_tready=1.
- step_div=4, target=+8, M_AXIS_tready=1 -> a phase step every 4 cycles; A/B sequence 1,2,3,0,1,2,3,0; A falls with B=high twice; busy is high for 32 cycles, then IDLE.
- From position 8, target=-4, step_div=1 -> 12 reverse steps, one per cycle; A falls with B=low three times; final phase 0.
- step_div=2, target=+4, M_AXIS_tready toggled 1,0,1,0 -> no step and tdata held during low cycles; completion takes 8 ready cycles.
- Target equal to current position (0) -> handshake accepted, busy stays 0, tdata unchanged.
- With POSITION_EMU_RETARGET_EN, target=+100, then target=+3 sent after 5 steps -> reverses, ends at 3, busy drops; without the macro the second word stalls (tready=0) until 100 is reached. Assert areset at step 50 -> outputs return to reset values asynchronously.
